key_pulse: RTL and testbench

Input conditioning stage directly upstream of `phase`: turns the two raw push-button levels into the clean, synchronous, single-cycle `start` and `stop` pulses that `phase` consumes. Each key is double-flop synchronized, debounced by a per-key stability counter, and edge-detected on press. Outputs connect one-to-one to `phase.start` / `phase.stop` on the same `CLK` / `RSTN`.

---
 rtl/key_pulse.sv | 97 +++++++++
 tb/tb_key_pulse.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/key_pulse.sv
// Push-button conditioner: per-key synchronize, debounce and press-edge detect,
// giving registered single-cycle start/stop pulses with stop taking priority.

module key_chan #(
  parameter int DB_CYCLES      = 4,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic key_raw,
  output logic press
);
  localparam int             CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic          key_n;
  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d, filt_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign key_n = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
    end
  end

  // Any cycle back at the accepted level restarts the stability count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) filt_d = sync2_q;
      else                  cnt_d  = cnt_q + CW'(1);
    end
  end

  assign press = filt_q & ~filt_dly_q;
endmodule

module key_pulse #(
  parameter int DB_CYCLES      = 4,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic start_key,
  input  logic stop_key,
  output logic start,
  output logic stop
);
  localparam int NUM_KEYS = 2;

  logic [NUM_KEYS-1:0] keys, press;
  logic                start_q, start_d, stop_q, stop_d;

  assign keys = {stop_key, start_key};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_chan #(.DB_CYCLES(DB_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_chan (
      .gclk    (CLK),
      .grst_n  (RSTN),
      .key_raw (keys[g]),
      .press   (press[g])
    );
  end

  // Same-cycle presses resolve to stop so downstream never sees both.
  always_comb begin
    start_d = press[0] & ~press[1];
    stop_d  = press[1];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign start = start_q;
  assign stop  = stop_q;
endmodule

// File: tb/tb_key_pulse.sv
// Directed and random stimulus for key_pulse against a sample-history model of
// the debounce rules (level accepted after DB consecutive differing samples).

module tb_key_pulse;
  localparam int DB = 4;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic start_key = 1'b1;
  logic stop_key  = 1'b1;
  logic start, stop;

  key_pulse #(.DB_CYCLES(DB), .KEY_ACTIVE_LOW(1)) dut (
    .CLK(CLK), .RSTN(RSTN), .start_key(start_key), .stop_key(stop_key),
    .start(start), .stop(stop)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int tcount = 0;
  int n_start, n_stop, first_start_t, first_stop_t;

  // model: hist[k] bit i = raw pressed level sampled i+1 edges ago
  logic [DB:0] m_hist [2];
  logic [1:0]  m_filt, m_rose;
  logic        exp_start, exp_stop;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hist[0] = '0; m_hist[1] = '0;
    m_filt = '0; m_rose = '0;
    exp_start = 1'b0; exp_stop = 1'b0;
  endtask

  task automatic clr_cnt();
    n_start = 0; n_stop = 0; first_start_t = -1; first_stop_t = -1;
  endtask

  task automatic tick();
    logic raw, all_diff;
    @(posedge CLK);
    tcount++;
    if (!RSTN) model_clear();
    else begin
      exp_start = m_rose[0] & ~m_rose[1];
      exp_stop  = m_rose[1];
      for (int k = 0; k < 2; k++) begin
        raw = (k == 0) ? ~start_key : ~stop_key;
        all_diff = 1'b1;
        for (int i = 1; i <= DB; i++)
          if (m_hist[k][i] == m_filt[k]) all_diff = 1'b0;
        m_rose[k] = all_diff & ~m_filt[k];
        if (all_diff) m_filt[k] = ~m_filt[k];
        m_hist[k] = {m_hist[k][DB-1:0], raw};
      end
    end
    #1;
    chk("start", start, exp_start);
    chk("stop", stop, exp_stop);
    if (start) begin
      n_start++;
      if (first_start_t < 0) first_start_t = tcount;
    end
    if (stop) begin
      n_stop++;
      if (first_stop_t < 0) first_stop_t = tcount;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset();
    #3 RSTN = 1'b0;
    #1;
    chk("rst_start", start, 0);
    chk("rst_stop", stop, 0);
    model_clear();
  endtask

  int e0;

  initial begin
    model_clear();
    clr_cnt();
    #1;
    chk("por_start", start, 0);
    chk("por_stop", stop, 0);
    ticks(3);
    RSTN = 1'b1;
    ticks(5);

    // clean press: pulse 6 edges after the first sampling edge
    clr_cnt();
    start_key = 1'b0; e0 = tcount + 1;
    ticks(20);
    start_key = 1'b1;
    ticks(10);
    chk("clean_n_start", n_start, 1);
    chk("clean_n_stop", n_stop, 0);
    chk("clean_latency", first_start_t - e0, 6);

    // bounce shorter than the debounce window is ignored
    clr_cnt();
    stop_key = 1'b0; ticks(3);
    stop_key = 1'b1; ticks(1);
    stop_key = 1'b0; ticks(2);
    stop_key = 1'b1; ticks(10);
    chk("bounce_n_stop", n_stop, 0);
    stop_key = 1'b0; ticks(10);
    stop_key = 1'b1; ticks(10);
    chk("bounce_then_press", n_stop, 1);

    // long hold then re-press: two pulses, none on release
    clr_cnt();
    start_key = 1'b0; ticks(100);
    start_key = 1'b1; ticks(10);
    start_key = 1'b0; ticks(10);
    start_key = 1'b1; ticks(10);
    chk("hold_n_start", n_start, 2);

    // simultaneous presses: stop wins
    clr_cnt();
    start_key = 1'b0; stop_key = 1'b0; ticks(10);
    start_key = 1'b1; stop_key = 1'b1; ticks(10);
    chk("simul_n_stop", n_stop, 1);
    chk("simul_n_start", n_start, 0);

    // presses one cycle apart both pulse, one cycle apart
    clr_cnt();
    stop_key = 1'b0; ticks(1);
    start_key = 1'b0; ticks(10);
    start_key = 1'b1; stop_key = 1'b1; ticks(10);
    chk("stagger_n_start", n_start, 1);
    chk("stagger_n_stop", n_stop, 1);
    chk("stagger_gap", first_start_t - first_stop_t, 1);

    // reset mid-debounce with key still held: fresh full-latency pulse
    clr_cnt();
    start_key = 1'b0; ticks(3);
    async_reset();
    ticks(2);
    RSTN = 1'b1; e0 = tcount + 1;
    ticks(10);
    start_key = 1'b1; ticks(10);
    chk("rst_hold_n_start", n_start, 1);
    chk("rst_hold_latency", first_start_t - e0, 6);

    // reset mid-debounce with key released during reset: nothing
    clr_cnt();
    start_key = 1'b0; ticks(3);
    async_reset();
    start_key = 1'b1;
    ticks(2);
    RSTN = 1'b1;
    ticks(15);
    chk("rst_rel_n_start", n_start, 0);

    // random bouncing keys with occasional resets, model checked every edge
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) start_key = ~start_key;
      if ($urandom_range(0, 5) == 0) stop_key  = ~stop_key;
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        ticks($urandom_range(1, 3));
        RSTN = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
